instruction_fetch_unit: RTL and testbench

Fetch-side counterpart of the instruction memory. Owns the program counter and drives the word address into the combinational instruction ROM. Captures the returned word with its PC into a small fetch queue, and hands {pc, instr} to decode over a valid/ready handshake. Branch and jump targets arrive on a redirect port that flushes the queue.

---
 rtl/instruction_fetch_unit.sv | 93 +++++++++
 tb/tb_instruction_fetch_unit.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch: PC register driving a combinational ROM, small fetch queue to decode.
// Optional ADDR_CHECK_EN macro stops fetching and raises fetch_fault when the PC leaves the ROM.
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2,
    parameter int          IMEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] dec_instr,
    output logic [31:0] dec_pc,
    output logic        fetch_fault
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    logic [31:0]      pc;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic [31:0]      q_pc    [FIFO_DEPTH];
    logic [31:0]      q_instr [FIFO_DEPTH];
    logic             pop;
    logic             push;
    logic             fetch_ok;
    logic             unused_redirect_lsb;

    assign unused_redirect_lsb = ^redirect_pc[1:0];

`ifdef ADDR_CHECK_EN
    localparam logic [32:0] IMEM_LIMIT = 33'(IMEM_WORDS) * 33'd4;

    // Fault follows the PC register, so it stays set until a redirect lands in range.
    assign fetch_ok    = ({1'b0, pc} < IMEM_LIMIT);
    assign fetch_fault = ~fetch_ok;
`else
    logic unused_imem_words;

    assign unused_imem_words = ^IMEM_WORDS;
    assign fetch_ok          = 1'b1;
    assign fetch_fault       = 1'b0;
`endif

    assign imem_addr = pc;
    assign dec_valid = (count != '0);
    assign pop       = dec_valid & dec_ready;
    assign push      = ~redirect_valid & fetch_ok &
                       ((count < CNT_W'(FIFO_DEPTH)) | pop);
    assign dec_pc    = dec_valid ? q_pc[rd_ptr]    : 32'h0;
    assign dec_instr = dec_valid ? q_instr[rd_ptr] : 32'h0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc     <= RESET_PC;
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else if (redirect_valid) begin
            pc     <= {redirect_pc[31:2], 2'b00};
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
                pc     <= pc + 32'd4;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: head outputs are masked by count.
    always_ff @(posedge clk) begin
        if (push) begin
            q_pc[wr_ptr]    <= pc;
            q_instr[wr_ptr] <= imem_instr;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: ROM model plus expected {pc, instr} scoreboard per scenario.
// Scenarios for ADDR_CHECK_EN run only when the macro is defined for the build.
module tb_instruction_fetch_unit;
    logic        clk;
    logic        rst_n;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_instr;
    logic [31:0] dec_pc;
    logic        fetch_fault;

    int          total = 0;
    int          bad   = 0;
    logic [63:0] sb [$];
    logic [63:0] exp_e;

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h2008_0005;
            32'h4:   return 32'h2009_000A;
            32'h8:   return 32'h0109_5020;
            32'hC:   return 32'h0000_0000;
            default: return 32'hA5A5_0000 ^ a;
        endcase
    endfunction

    assign imem_instr = rom_word(imem_addr);

    instruction_fetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .FIFO_DEPTH(2),
        .IMEM_WORDS(64)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_addr     (imem_addr),
        .imem_instr    (imem_instr),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .dec_valid     (dec_valid),
        .dec_ready     (dec_ready),
        .dec_instr     (dec_instr),
        .dec_pc        (dec_pc),
        .fetch_fault   (fetch_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [63:0] ent(input logic [31:0] p);
        return {p, rom_word(p)};
    endfunction

    // Stimulus only: leave the queue holding pc 4, 8 with pc register at 0xC.
    task automatic fill_48();
        rst_n = 1'b0; dec_ready = 1'b0; redirect_valid = 1'b0;
        #1;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 dec_ready = 1'b1;
        @(posedge clk);
        #1 dec_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; dec_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
        #2;
        total++; if (dec_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", dec_valid); end
        total++; if (dec_pc !== 32'h0) begin bad++; $display("FAIL reset_pc got=%h exp=0", dec_pc); end
        total++; if (dec_instr !== 32'h0) begin bad++; $display("FAIL reset_instr got=%h exp=0", dec_instr); end
        total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL reset_addr got=%h exp=0", imem_addr); end
        total++; if (fetch_fault !== 1'b0) begin bad++; $display("FAIL reset_fault got=%b exp=0", fetch_fault); end
    endtask

    task automatic test_stream();
        dec_ready = 1'b1;
        @(negedge clk) rst_n = 1'b1;
        #1;
        total++; if (dec_valid !== 1'b0) begin bad++; $display("FAIL stream_pre_valid got=%b exp=0", dec_valid); end
        @(posedge clk) #1;
        total++; if (dec_valid !== 1'b1) begin bad++; $display("FAIL stream_first_valid got=%b exp=1", dec_valid); end
        sb.push_back(ent(32'h0)); sb.push_back(ent(32'h4));
        sb.push_back(ent(32'h8)); sb.push_back(ent(32'hC));
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++; if (dec_valid !== 1'b1) begin bad++; $display("FAIL stream_gap cycle=%0d got=%b exp=1", i, dec_valid); end
            if (dec_valid && dec_ready) begin
                total++;
                if (sb.size() == 0) begin bad++; $display("FAIL stream_extra_pop pc=%h", dec_pc); end
                else begin
                    exp_e = sb.pop_front();
                    if ({dec_pc, dec_instr} !== exp_e) begin bad++; $display("FAIL stream_pop got=%h exp=%h", {dec_pc, dec_instr}, exp_e); end
                end
            end
        end
        total++; if (sb.size() != 0) begin bad++; $display("FAIL stream_left got=%0d exp=0", sb.size()); sb.delete(); end
    endtask

    task automatic test_backpressure();
        rst_n = 1'b0; dec_ready = 1'b0;
        #1;
        @(negedge clk) rst_n = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        total++; if (imem_addr !== 32'h8) begin bad++; $display("FAIL bp_addr got=%h exp=8", imem_addr); end
        total++; if (dec_pc !== 32'h0) begin bad++; $display("FAIL bp_head got=%h exp=0", dec_pc); end
        total++; if (dec_valid !== 1'b1) begin bad++; $display("FAIL bp_valid got=%b exp=1", dec_valid); end
        sb.push_back(ent(32'h0)); sb.push_back(ent(32'h4)); sb.push_back(ent(32'h8));
        @(posedge clk) #1 dec_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            total++; if (dec_valid !== 1'b1) begin bad++; $display("FAIL bp_gap cycle=%0d got=%b exp=1", i, dec_valid); end
            if (dec_valid && dec_ready) begin
                total++;
                if (sb.size() == 0) begin bad++; $display("FAIL bp_extra_pop pc=%h", dec_pc); end
                else begin
                    exp_e = sb.pop_front();
                    if ({dec_pc, dec_instr} !== exp_e) begin bad++; $display("FAIL bp_pop got=%h exp=%h", {dec_pc, dec_instr}, exp_e); end
                end
            end
        end
        total++; if (sb.size() != 0) begin bad++; $display("FAIL bp_left got=%0d exp=0", sb.size()); sb.delete(); end
    endtask

    task automatic test_redirect();
        fill_48();
        redirect_valid = 1'b1; redirect_pc = 32'h23;
        @(posedge clk) #1 redirect_valid = 1'b0; dec_ready = 1'b1;
        total++; if (dec_valid !== 1'b0) begin bad++; $display("FAIL redir_bubble got=%b exp=0", dec_valid); end
        total++; if (imem_addr !== 32'h20) begin bad++; $display("FAIL redir_addr got=%h exp=20", imem_addr); end
        @(posedge clk) #1;
        total++; if (dec_valid !== 1'b1) begin bad++; $display("FAIL redir_valid got=%b exp=1", dec_valid); end
        total++; if ({dec_pc, dec_instr} !== ent(32'h20)) begin bad++; $display("FAIL redir_target got=%h exp=%h", {dec_pc, dec_instr}, ent(32'h20)); end

        fill_48();
        dec_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h40;
        sb.push_back(ent(32'h4)); sb.push_back(ent(32'h40));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i == 1) begin
                total++; if (dec_valid !== 1'b0) begin bad++; $display("FAIL redir_pop_bubble got=%b exp=0", dec_valid); end
            end
            if (dec_valid && dec_ready) begin
                total++;
                if (sb.size() == 0) begin bad++; $display("FAIL redir_extra_pop pc=%h", dec_pc); end
                else begin
                    exp_e = sb.pop_front();
                    if ({dec_pc, dec_instr} !== exp_e) begin bad++; $display("FAIL redir_pop got=%h exp=%h", {dec_pc, dec_instr}, exp_e); end
                end
            end
            @(posedge clk) #1 redirect_valid = 1'b0;
        end
        total++; if (sb.size() != 0) begin bad++; $display("FAIL redir_left got=%0d exp=0", sb.size()); sb.delete(); end
    endtask

    task automatic test_async_reset();
        dec_ready = 1'b1;
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        total++; if (dec_valid !== 1'b0) begin bad++; $display("FAIL arst_valid got=%b exp=0", dec_valid); end
        total++; if (dec_pc !== 32'h0) begin bad++; $display("FAIL arst_pc got=%h exp=0", dec_pc); end
        total++; if (dec_instr !== 32'h0) begin bad++; $display("FAIL arst_instr got=%h exp=0", dec_instr); end
        total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL arst_addr got=%h exp=0", imem_addr); end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk) #1;
        total++; if ({dec_valid, dec_pc, dec_instr} !== {1'b1, ent(32'h0)}) begin
            bad++; $display("FAIL arst_restart got=%h exp=%h", {dec_valid, dec_pc, dec_instr}, {1'b1, ent(32'h0)});
        end
    endtask

    task automatic test_wrap();
        @(posedge clk) #1 dec_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
        sb.push_back(ent(32'hFFFF_FFF8)); sb.push_back(ent(32'hFFFF_FFFC)); sb.push_back(ent(32'h0));
        @(posedge clk) #1 redirect_valid = 1'b0; dec_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (dec_valid && dec_ready) begin
                total++;
                if (sb.size() == 0) begin bad++; $display("FAIL wrap_extra_pop pc=%h", dec_pc); end
                else begin
                    exp_e = sb.pop_front();
                    if ({dec_pc, dec_instr} !== exp_e) begin bad++; $display("FAIL wrap_pop got=%h exp=%h", {dec_pc, dec_instr}, exp_e); end
                end
            end
        end
        total++; if (sb.size() != 0) begin bad++; $display("FAIL wrap_left got=%0d exp=0", sb.size()); sb.delete(); end
    endtask

`ifdef ADDR_CHECK_EN
    task automatic test_addr_check();
        rst_n = 1'b0; dec_ready = 1'b1; redirect_valid = 1'b0;
        #1;
        @(negedge clk) rst_n = 1'b1;
        for (int k = 0; k < 64; k++) sb.push_back(ent(32'(k * 4)));
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            if (dec_valid && dec_ready) begin
                total++;
                if (sb.size() == 0) begin bad++; $display("FAIL addr_extra_pop pc=%h", dec_pc); end
                else begin
                    exp_e = sb.pop_front();
                    if ({dec_pc, dec_instr} !== exp_e) begin bad++; $display("FAIL addr_pop got=%h exp=%h", {dec_pc, dec_instr}, exp_e); end
                end
            end
        end
        total++; if (sb.size() != 0) begin bad++; $display("FAIL addr_left got=%0d exp=0", sb.size()); sb.delete(); end
        total++; if (fetch_fault !== 1'b1) begin bad++; $display("FAIL addr_fault got=%b exp=1", fetch_fault); end
        total++; if (dec_valid !== 1'b0) begin bad++; $display("FAIL addr_drained got=%b exp=0", dec_valid); end
        total++; if (imem_addr !== 32'h100) begin bad++; $display("FAIL addr_hold got=%h exp=100", imem_addr); end
        @(posedge clk) #1 dec_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h0;
        @(posedge clk) #1 redirect_valid = 1'b0;
        total++; if (fetch_fault !== 1'b0) begin bad++; $display("FAIL addr_clear got=%b exp=0", fetch_fault); end
        @(posedge clk) #1;
        total++; if ({dec_valid, dec_pc, dec_instr} !== {1'b1, ent(32'h0)}) begin
            bad++; $display("FAIL addr_refetch got=%h exp=%h", {dec_valid, dec_pc, dec_instr}, {1'b1, ent(32'h0)});
        end
    endtask
`endif

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_async_reset();
        test_wrap();
`ifdef ADDR_CHECK_EN
        test_addr_check();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
